// File: rtl/zero_pad_stream_pkg.sv
// Shared CNN front-end package: default image geometry, pixel width and the
// padding FSM state type.
package zero_pad_stream_pkg;

  localparam int DATA_W   = 16;
  localparam int IMG_SIZE = 28;
  localparam int PAD      = 1;
  localparam int OUT_SIZE = IMG_SIZE + 2 * PAD;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } pad_state_t;

endpackage

// File: rtl/zero_pad_stream_if.sv
// Pixel stream bundle between the upstream source, the zero-pad block and the
// 3x3 line-buffer stage.
//   start      : one-cycle frame start pulse
//   pixel_in   : unpadded signed pixel, qualified by valid_in
//   ready_out  : pad block consumes pixel_in this cycle
//   pixel_out  : padded signed pixel, qualified by valid_out
//   busy       : frame in progress
//   frame_done : pulse alongside the last padded pixel
// slave = the zero-pad block, master = the stream source / sink side.
interface zero_pad_stream_if
  import zero_pad_stream_pkg::*;
#(
  parameter int DATA_W = zero_pad_stream_pkg::DATA_W
);

  logic                     start;
  logic signed [DATA_W-1:0] pixel_in;
  logic                     valid_in;
  logic                     ready_out;
  logic signed [DATA_W-1:0] pixel_out;
  logic                     valid_out;
  logic                     busy;
  logic                     frame_done;

  modport slave (
    input  start, pixel_in, valid_in,
    output ready_out, pixel_out, valid_out, busy, frame_done
  );

  modport master (
    output start, pixel_in, valid_in,
    input  ready_out, pixel_out, valid_out, busy, frame_done
  );

endinterface

// File: rtl/zero_pad_stream_pad_pos_counter.sv
// Row/column position counter over the padded raster.
//   clk, reset_n : clock, synchronous active-low reset
//   adv          : step one position (column first, then row)
//   row, col     : current padded position
//   last         : current position is the final (OUT_SIZE-1, OUT_SIZE-1)
module pad_pos_counter
  import zero_pad_stream_pkg::*;
#(
  parameter int OUT_SIZE = zero_pad_stream_pkg::OUT_SIZE,
  localparam int CW      = $clog2(OUT_SIZE)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          adv,
  output logic [CW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last
);

  localparam logic [CW-1:0] MAX = CW'(OUT_SIZE - 1);

  // Stepping past the last position wraps both counters back to (0,0), so
  // the next frame starts clean without an explicit clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      row <= '0;
      col <= '0;
    end else if (adv) begin
      if (col == MAX) begin
        col <= '0;
        row <= (row == MAX) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  assign last = (row == MAX) && (col == MAX);

endmodule

// File: rtl/zero_pad_stream.sv
// Zero-pad stream: wraps an IMG_SIZE x IMG_SIZE raster in a PAD-wide zero
// border, producing an OUT_SIZE x OUT_SIZE raster for the 3x3 line buffer.
//   clk, reset_n : clock, synchronous active-low reset
//   bus (slave)  : start / pixel_in / valid_in / ready_out upstream,
//                  pixel_out / valid_out / busy / frame_done downstream
module zero_pad_stream
  import zero_pad_stream_pkg::*;
#(
  parameter int IMG_SIZE = zero_pad_stream_pkg::IMG_SIZE,
  parameter int PAD      = zero_pad_stream_pkg::PAD,
  parameter int DATA_W   = zero_pad_stream_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  zero_pad_stream_if.slave  bus
);

  localparam int OUT_SIZE = IMG_SIZE + 2 * PAD;
  localparam int CW       = $clog2(OUT_SIZE);

  function automatic logic is_border(input logic [CW-1:0] r, input logic [CW-1:0] c);
    return (r < CW'(PAD)) || (r >= CW'(PAD + IMG_SIZE)) ||
           (c < CW'(PAD)) || (c >= CW'(PAD + IMG_SIZE));
  endfunction

  pad_state_t               state_p1;
  logic [CW-1:0]            row_p0;
  logic [CW-1:0]            col_p0;
  logic                     last_p0;
  logic                     border_p0;
  logic                     adv_p0;
  logic signed [DATA_W-1:0] pixel_p1;
  logic                     vld_p1;
  logic                     done_p1;
  logic                     busy_p1;

  pad_pos_counter #(
    .OUT_SIZE (OUT_SIZE)
  ) u_pos (
    .clk     (clk),
    .reset_n (reset_n),
    .adv     (adv_p0),
    .row     (row_p0),
    .col     (col_p0),
    .last    (last_p0)
  );

  // Stage p0: position decision. Border positions advance unconditionally;
  // interior positions advance only when a pixel is actually handed over.
  assign border_p0     = is_border(row_p0, col_p0);
  assign adv_p0        = (state_p1 == ACTIVE) && (border_p0 || bus.valid_in);
  assign bus.ready_out = reset_n && (state_p1 == ACTIVE) && !border_p0;

  // Stage p1: registered outputs and FSM.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_p1 <= IDLE;
      busy_p1  <= 1'b0;
      vld_p1   <= 1'b0;
      done_p1  <= 1'b0;
      pixel_p1 <= '0;
    end else begin
      vld_p1  <= adv_p0;
      done_p1 <= adv_p0 && last_p0;
      if (adv_p0) begin
        pixel_p1 <= border_p0 ? '0 : bus.pixel_in;
      end
      unique case (state_p1)
        IDLE: begin
          // done_p1 high means the frame ended on the previous edge; a start
          // landing in that cycle is dropped so frames never chain implicitly.
          if (bus.start && !done_p1) begin
            state_p1 <= ACTIVE;
            busy_p1  <= 1'b1;
          end else begin
            busy_p1  <= 1'b0;
          end
        end
        ACTIVE: begin
          busy_p1 <= 1'b1;
          if (adv_p0 && last_p0) begin
            state_p1 <= IDLE;
          end
        end
        default: state_p1 <= IDLE;
      endcase
    end
  end

  assign bus.pixel_out  = pixel_p1;
  assign bus.valid_out  = vld_p1;
  assign bus.frame_done = done_p1;
  assign bus.busy       = busy_p1;

endmodule

// File: doc/zero_pad_stream.md
ZERO_PAD_STREAM -- requirements
Module: zero_pad_stream

Interface
REQ-001 Parameter IMG_SIZE, default 28, unpadded image edge length in pixels.
REQ-002 Parameter PAD, default 1, zero border width on each side; padded edge OUT_SIZE = IMG_SIZE+2*PAD, 30 by default.
REQ-003 Parameter DATA_W, default 16, signed pixel width.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 reset_n  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  one-cycle pulse that begins a padded frame.
REQ-007 pixel_in  input  DATA_W signed  unpadded raster pixel from upstream.
REQ-008 valid_in  input  1  pixel_in is valid.
REQ-009 ready_out  output  1  block accepts pixel_in this cycle.
REQ-010 pixel_out  output  DATA_W signed  padded raster pixel for the 3x3 line-buffer stage.
REQ-011 valid_out  output  1  pixel_out is valid; the downstream stage always accepts.
REQ-012 busy  output  1  frame in progress.
REQ-013 frame_done  output  1  one-cycle pulse with the last padded pixel.

Function
REQ-014 FSM states: IDLE, ACTIVE; IDLE->ACTIVE on start; ACTIVE->IDLE after position (OUT_SIZE-1, OUT_SIZE-1) is emitted.
REQ-015 In ACTIVE, row and column counters, each $clog2(OUT_SIZE) bits, walk the padded raster left-to-right then top-to-bottom; the column wraps to 0 at OUT_SIZE-1 and increments the row.
REQ-016 Border position: row<PAD, row>=PAD+IMG_SIZE, col<PAD or col>=PAD+IMG_SIZE.
REQ-017 At a border position the block emits 0 with valid_out=1 and advances one position per cycle, independent of valid_in.
REQ-018 At an interior position, ready_out=1 (combinational from state and counters).
REQ-019 At an interior position with valid_in=1, the block emits pixel_in and advances.
REQ-020 At an interior position with valid_in=0, the block stalls: counters hold and valid_out=0 next cycle.
REQ-021 ready_out=0 in IDLE and at every border position; valid_in while ready_out=0 is ignored and the pixel is not consumed.
REQ-022 pixel_out, valid_out and frame_done are registered with one-cycle latency from the position decision; pixel_out holds its last value when valid_out=0.
REQ-023 frame_done=1 in the same cycle valid_out carries the pixel at position (OUT_SIZE-1, OUT_SIZE-1).
REQ-024 busy=1 from the cycle after start through the cycle frame_done is asserted, inclusive.
REQ-025 start while ACTIVE is ignored.
REQ-026 start in the cycle the FSM returns to IDLE is ignored; a new frame needs start while IDLE.
REQ-027 Exactly OUT_SIZE*OUT_SIZE valid_out pulses and IMG_SIZE*IMG_SIZE accepted inputs per frame.
REQ-028 With valid_in held high, a frame takes exactly OUT_SIZE*OUT_SIZE cycles, 900 by default.
REQ-029 pixel_in passes through bit-exact, with no sign change or truncation.

Reset
REQ-030 On a clk edge with reset_n=0: FSM=IDLE, counters=0, pixel_out=0, valid_out=0, frame_done=0, busy=0.
REQ-031 ready_out=0 during reset.
REQ-032 reset_n asserted mid-frame aborts the frame immediately with no frame_done; the next start begins a fresh frame at (0,0).

Structure
REQ-033 The shared CNN package holds DATA_W, IMG_SIZE, PAD, the derived OUT_SIZE and the FSM state enum typedef.
REQ-034 One sub-module, pad_pos_counter, holds the row/column wrap counter with an advance enable and a last-position flag; the FSM and datapath stay in the top.

Verification
REQ-035 Reset, start, valid_in=1 with inputs 1..784 -> 900 outputs; rows 0 and 29 and columns 0 and 29 are zero; output (1,1)=1, (28,28)=784; frame_done only at output 900.
REQ-036 Start, random valid_in gaps (~30% low) -> the same 900-value sequence as REQ-035; no input lost or duplicated; ready_out never high at a border position.
REQ-037 Start, valid_in=0 after 10 accepted pixels for 50 cycles -> valid_out=0 and counters frozen for 50 cycles; resume matches the reference sequence.
REQ-038 Negative inputs -32768 and -1 at interior positions -> identical signed values at pixel_out.
REQ-039 reset_n low for 1 cycle at output 400 -> all outputs 0 next cycle, no frame_done; a subsequent start yields a full correct frame.
REQ-040 start pulsed mid-frame and again at the frame_done cycle -> both ignored; a later start while IDLE yields one new correct frame; outputs feed line_buffer and produce 784 valid 3x3 windows.
